// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles everything between the two requesters (instruction fetch and
// load/store), the shared single-port data memory, and the arbiter.
//
// Signals, named from the arbiter's point of view:
//   i_if_req, i_if_addr                      fetch request (read only)
//   o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err
//   i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata  load/store request
//   o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err
//   o_we, o_addr, o_wdata                    memory command port
//   i_rdata                                  memory read data (1-cycle latency)
//
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_err;

  logic              i_ls_req;
  logic              i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic              o_ls_gnt;
  logic              o_ls_rvalid;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_ls_err;

  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W-1:0] i_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    output o_we, o_addr, o_wdata,
    input  i_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    input  o_we, o_addr, o_wdata,
    output i_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous single-port data memory between instruction fetch
// (IF, read only) and the load/store unit (LS). Load/store has priority, but
// after STARVE_LIMIT consecutive IF losses IF wins the next conflict. Grants
// are combinational, so one access per cycle is possible. Read data is routed
// back to the requester that owned the grant one cycle earlier. Misaligned or
// out-of-range requests are accepted (granted) but never reach the memory;
// the requester instead sees an error pulse in the following cycle.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave: both request ports, both response
//            ports and the memory command/read-data port
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_WORDS    = 2048,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_LS
  } owner_e;

  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
  // One extra bit so the byte size of the memory is representable even when
  // it fills the whole address space.
  localparam logic [ADDR_W:0] MEM_BYTES  = (ADDR_W+1)'(MEM_WORDS * 4);

  owner_e            owner_q, owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              if_err_q, if_err_d;
  logic              ls_err_q, ls_err_d;

  logic              if_gnt;
  logic              ls_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_legal;

  // Grant selection. Grants are held off while reset is asserted so that no
  // request is considered transferred and every output reads zero.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (i_rst_n) begin
      if (bus.i_if_req && bus.i_ls_req) begin
        if (starve_cnt_q == STARVE_MAX) begin
          if_gnt = 1'b1;
        end else begin
          ls_gnt = 1'b1;
        end
      end else if (bus.i_ls_req) begin
        ls_gnt = 1'b1;
      end else if (bus.i_if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Legality of whichever request was granted: word aligned and inside the
  // memory. An illegal grant drives an all-zero idle command to the memory.
  always_comb begin
    gnt_addr  = ls_gnt ? bus.i_ls_addr : bus.i_if_addr;
    gnt_legal = (if_gnt || ls_gnt) &&
                (gnt_addr[1:0] == 2'b00) &&
                ({1'b0, gnt_addr} < MEM_BYTES);
  end

  // Next owner, error flags and starvation count.
  always_comb begin
    owner_d      = OWNER_NONE;
    if_err_d     = 1'b0;
    ls_err_d     = 1'b0;
    starve_cnt_d = starve_cnt_q;

    if (gnt_legal && if_gnt) begin
      owner_d = OWNER_IF;
    end else if (gnt_legal && ls_gnt && !bus.i_ls_we) begin
      owner_d = OWNER_LS;
    end

    if_err_d = if_gnt && !gnt_legal;
    ls_err_d = ls_gnt && !gnt_legal;

    if (!bus.i_if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State register; reset also drops any read that is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q      <= OWNER_NONE;
      starve_cnt_q <= 4'd0;
      if_err_q     <= 1'b0;
      ls_err_q     <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      if_err_q     <= if_err_d;
      ls_err_q     <= ls_err_d;
    end
  end

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_ls_gnt    = ls_gnt;

  assign bus.o_we        = gnt_legal && ls_gnt && bus.i_ls_we;
  assign bus.o_addr      = gnt_legal ? gnt_addr       : '0;
  assign bus.o_wdata     = gnt_legal ? bus.i_ls_wdata : '0;

  // The memory's read data is steered to the owner only; the other side
  // sees zero.
  assign bus.o_if_rvalid = (owner_q == OWNER_IF);
  assign bus.o_ls_rvalid = (owner_q == OWNER_LS);
  assign bus.o_if_rdata  = (owner_q == OWNER_IF) ? bus.i_rdata : '0;
  assign bus.o_ls_rdata  = (owner_q == OWNER_LS) ? bus.i_rdata : '0;

  assign bus.o_if_err    = if_err_q;
  assign bus.o_ls_err    = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Contains a synchronous-read memory
// model attached to the arbiter's memory port, a table of single-cycle
// vectors (request in, grant/command/response expected), and hand-written
// sequences for reset during a read, IF starvation and back-to-back loads.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2048;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_WORDS   (MEM_WORDS),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: write and read both on the rising edge.
  always @(posedge clk) begin
    if (bus.o_we) begin
      mem[bus.o_addr[12:2]] <= bus.o_wdata;
    end
    bus.i_rdata <= mem[bus.o_addr[12:2]];
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        exp_if_gnt;
    logic        exp_ls_gnt;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_if_rvalid;
    logic [31:0] exp_if_rdata;
    logic        exp_ls_rvalid;
    logic [31:0] exp_ls_rdata;
    logic        exp_if_err;
    logic        exp_ls_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic if_req, input logic [31:0] if_addr,
                                input logic ls_req, input logic ls_we,
                                input logic [31:0] ls_addr, input logic [31:0] ls_wdata);
    bus.i_if_req   = if_req;
    bus.i_if_addr  = if_addr;
    bus.i_ls_req   = ls_req;
    bus.i_ls_we    = ls_we;
    bus.i_ls_addr  = ls_addr;
    bus.i_ls_wdata = ls_wdata;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit   ({tag, " if_gnt"},    bus.o_if_gnt,    1'b0);
    check_bit   ({tag, " ls_gnt"},    bus.o_ls_gnt,    1'b0);
    check_bit   ({tag, " if_rvalid"}, bus.o_if_rvalid, 1'b0);
    check_bit   ({tag, " ls_rvalid"}, bus.o_ls_rvalid, 1'b0);
    check_bit   ({tag, " if_err"},    bus.o_if_err,    1'b0);
    check_bit   ({tag, " ls_err"},    bus.o_ls_err,    1'b0);
    check_bit   ({tag, " we"},        bus.o_we,        1'b0);
    check_output({tag, " if_rdata"},  bus.o_if_rdata,  32'h0);
    check_output({tag, " ls_rdata"},  bus.o_ls_rdata,  32'h0);
    check_output({tag, " addr"},      bus.o_addr,      32'h0);
    check_output({tag, " wdata"},     bus.o_wdata,     32'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = 32'hA000_0000 + 32'(i);
    end
    mem[2] = 32'hDEAD_BEEF;

    // Field order: if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
    //   exp_if_gnt, exp_ls_gnt, exp_we, exp_addr, exp_wdata,
    //   exp_if_rvalid, exp_if_rdata, exp_ls_rvalid, exp_ls_rdata,
    //   exp_if_err, exp_ls_err
    // Response fields describe what is visible in that same cycle, i.e. the
    // result of the previous vector's grant.
    vecs[0]  = '{1'b1, 32'h8,    1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 1'b0, 1'b0, 32'h8,    32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0,    1'b1, 1'b1, 32'h4,    32'h1234_5678,
                 1'b0, 1'b1, 1'b1, 32'h4,    32'h1234_5678,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h4,    32'h0,
                 1'b0, 1'b1, 1'b0, 32'h4,    32'h0,
                 1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h6,    32'h0,
                 1'b0, 1'b1, 1'b0, 32'h0,    32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h2000, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h1FFC, 32'h55AA_55AA,
                 1'b0, 1'b1, 1'b1, 32'h1FFC, 32'h55AA_55AA,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h0BAD_F00D,
                 1'b0, 1'b1, 1'b0, 32'h0,    32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h1FFC, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 1'b0, 1'b0, 32'h1FFC, 32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,
                 1'b1, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0, 1'b0};

    // Reset held from time zero.
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reset mid-read: IF read of 0x10 granted, reset pulled before the edge.
    @(negedge clk);
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_bit   ("midrd if_gnt", bus.o_if_gnt, 1'b1);
    check_output("midrd addr",   bus.o_addr,   32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrd in reset");
    @(negedge clk);
    #1;
    check_all_zero("midrd after edge");
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    check_bit("midrd released if_rvalid", bus.o_if_rvalid, 1'b0);
    @(negedge clk);
    #1;
    check_bit("midrd next if_rvalid", bus.o_if_rvalid, 1'b0);

    // Table-driven single-cycle vectors.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      apply_stimulus(vecs[v].if_req, vecs[v].if_addr, vecs[v].ls_req,
                     vecs[v].ls_we, vecs[v].ls_addr, vecs[v].ls_wdata);
      #1;
      check_bit   ($sformatf("v%0d if_gnt", v),    bus.o_if_gnt,    vecs[v].exp_if_gnt);
      check_bit   ($sformatf("v%0d ls_gnt", v),    bus.o_ls_gnt,    vecs[v].exp_ls_gnt);
      check_bit   ($sformatf("v%0d we", v),        bus.o_we,        vecs[v].exp_we);
      check_output($sformatf("v%0d addr", v),      bus.o_addr,      vecs[v].exp_addr);
      check_output($sformatf("v%0d wdata", v),     bus.o_wdata,     vecs[v].exp_wdata);
      check_bit   ($sformatf("v%0d if_rvalid", v), bus.o_if_rvalid, vecs[v].exp_if_rvalid);
      check_output($sformatf("v%0d if_rdata", v),  bus.o_if_rdata,  vecs[v].exp_if_rdata);
      check_bit   ($sformatf("v%0d ls_rvalid", v), bus.o_ls_rvalid, vecs[v].exp_ls_rvalid);
      check_output($sformatf("v%0d ls_rdata", v),  bus.o_ls_rdata,  vecs[v].exp_ls_rdata);
      check_bit   ($sformatf("v%0d if_err", v),    bus.o_if_err,    vecs[v].exp_if_err);
      check_bit   ($sformatf("v%0d ls_err", v),    bus.o_ls_err,    vecs[v].exp_ls_err);
    end

    // Starvation: both request continuously. LS wins four times, IF wins
    // the fifth cycle, then LS wins again once the count has cleared.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      apply_stimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      check_bit   ($sformatf("starve c%0d if_gnt", c), bus.o_if_gnt, (c == 4));
      check_bit   ($sformatf("starve c%0d ls_gnt", c), bus.o_ls_gnt, (c != 4));
      check_output($sformatf("starve c%0d addr", c),   bus.o_addr,   (c == 4) ? 32'h0 : 32'h8);
    end

    // Flush with idle cycles.
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Back-to-back loads at 0x0, 0x4, 0x8; data returns on three
    // consecutive cycles in order.
    for (int c = 0; c < 5; c++) begin
      logic [31:0] exp_data;
      @(negedge clk);
      if (c < 3) begin
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'(c * 4), 32'h0);
      end else begin
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      #1;
      case (c)
        1:       exp_data = 32'hA000_0000;
        2:       exp_data = 32'h1234_5678;
        3:       exp_data = 32'hDEAD_BEEF;
        default: exp_data = 32'h0;
      endcase
      check_bit   ($sformatf("b2b c%0d ls_gnt", c),    bus.o_ls_gnt,    (c < 3));
      check_bit   ($sformatf("b2b c%0d ls_rvalid", c), bus.o_ls_rvalid, (c >= 1 && c <= 3));
      check_output($sformatf("b2b c%0d ls_rdata", c),  bus.o_ls_rdata,  exp_data);
      check_bit   ($sformatf("b2b c%0d if_rvalid", c), bus.o_if_rvalid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
